// File: rtl/bus_host_arbiter_pkg.sv
// Shared types and constants for the bus host arbiter.
// The BUS_ARB_STATS_EN build option (per-host transfer counters) is handled in bus_host_arbiter.sv.
package bus_host_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int HOLD_CNT_W = 8;
    localparam int STAT_W     = 16;
    localparam int HOST_IDX_W = 3;

    function automatic int host_idx_w(input int hosts);
        return (hosts > 1) ? $clog2(hosts) : 1;
    endfunction

    typedef struct packed {
        arb_state_e              state;
        logic [HOST_IDX_W-1:0]   owner;
        logic [HOLD_CNT_W-1:0]   hold;
        logic                    rd_pend;
    } arb_dbg_t;

endpackage

// File: rtl/bus_host_arbiter_if.sv
// Host-side and device-side signals of the shared bus port.
// Handshake: a host holds req/addr/we/wdata stable until its gnt pulses; gnt marks the
// accepted cycle. A read's data returns exactly one cycle later with a one-cycle rvalid.
interface bus_host_arbiter_if #(
    parameter int Hosts        = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) ();
    logic [Hosts-1:0]              h_req_in;
    logic [Hosts*AddressWidth-1:0] h_addr_in;
    logic [Hosts-1:0]              h_we_in;
    logic [Hosts*DataWidth-1:0]    h_wdata_in;
    logic [Hosts-1:0]              h_gnt_out;
    logic [Hosts-1:0]              h_rvalid_out;
    logic [DataWidth-1:0]          h_rdata_out;
    logic                          d_req_out;
    logic [AddressWidth-1:0]       d_addr_out;
    logic                          d_we_out;
    logic [DataWidth-1:0]          d_wdata_out;
    logic                          d_gnt_in;
    logic [DataWidth-1:0]          d_rdata_in;

    modport slave (
        input  h_req_in, h_addr_in, h_we_in, h_wdata_in, d_gnt_in, d_rdata_in,
        output h_gnt_out, h_rvalid_out, h_rdata_out, d_req_out, d_addr_out, d_we_out, d_wdata_out
    );

    modport master (
        output h_req_in, h_addr_in, h_we_in, h_wdata_in, d_gnt_in, d_rdata_in,
        input  h_gnt_out, h_rvalid_out, h_rdata_out, d_req_out, d_addr_out, d_we_out, d_wdata_out
    );
endinterface

// File: rtl/bus_host_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module bus_host_arbiter_rr_picker
    import bus_host_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = host_idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_oh_o,
    output logic [IW-1:0] grant_idx_o
);
    always_comb begin
        logic          found;
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
            idx = sum[IW-1:0];
            if (!found && req_i[idx]) begin
                found           = 1'b1;
                grant_oh_o[idx] = 1'b1;
                grant_idx_o     = idx;
            end
        end
    end
endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one device port among several hosts, with a hold limit.
// Define BUS_ARB_STATS_EN to build per-host saturating accepted-transfer counters.
module bus_host_arbiter
    import bus_host_arbiter_pkg::*;
#(
    parameter int Hosts        = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int MaxHold      = 4
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    bus_host_arbiter_if.slave       bus,
    output logic [Hosts*STAT_W-1:0] stat_xfer_cnt_out,
    output arb_dbg_t                dbg_out
);
    localparam int IdxW = host_idx_w(Hosts);
    localparam logic [HOLD_CNT_W-1:0] HoldMax  = HOLD_CNT_W'(MaxHold);
    localparam logic [IdxW-1:0]       LastHost = IdxW'(Hosts - 1);

    arb_state_e            state_q, state_d;
    logic [IdxW-1:0]       owner_q, owner_d, rr_q, rr_d, rd_owner_q, rd_owner_d;
    logic [HOLD_CNT_W-1:0] hold_q, hold_d, hold_inc;
    logic                  rd_pend_q, rd_pend_d;
    logic [Hosts-1:0]      pick_oh, owner_oh, rd_oh;
    logic [IdxW-1:0]       pick_idx, rr_next;
    logic                  owner_req, owner_we, others_req, dev_req, accept, active;
    logic [AddressWidth-1:0] owner_addr;
    logic [DataWidth-1:0]    owner_wdata;

    bus_host_arbiter_rr_picker #(.N(Hosts), .IW(IdxW)) u_picker (
        .req_i      (bus.h_req_in),
        .ptr_i      (rr_q),
        .grant_oh_o (pick_oh),
        .grant_idx_o(pick_idx)
    );

    always_comb begin
        owner_addr  = '0;
        owner_wdata = '0;
        owner_oh    = '0;
        rd_oh       = '0;
        for (int i = 0; i < Hosts; i++) begin
            if (owner_q == IdxW'(i)) begin
                owner_addr  = bus.h_addr_in[i*AddressWidth +: AddressWidth];
                owner_wdata = bus.h_wdata_in[i*DataWidth +: DataWidth];
                owner_oh[i] = 1'b1;
            end
            if (rd_owner_q == IdxW'(i)) rd_oh[i] = 1'b1;
        end
    end

    assign owner_req  = |(bus.h_req_in & owner_oh);
    assign owner_we   = |(bus.h_we_in & owner_oh);
    assign others_req = |(bus.h_req_in & ~owner_oh);
    assign hold_inc   = (hold_q >= HoldMax) ? hold_q : hold_q + 1'b1;
    assign rr_next    = (owner_q == LastHost) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        hold_d     = hold_q;
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        dev_req    = 1'b0;
        accept     = 1'b0;
        if (!reset_in) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (|pick_oh) begin
                        owner_d = pick_idx;
                        hold_d  = '0;
                        state_d = ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    dev_req = owner_req;
                    accept  = dev_req && bus.d_gnt_in;
                    if (accept) begin
                        hold_d = hold_inc;
                        if (!owner_we) begin
                            rd_pend_d  = 1'b1;
                            rd_owner_d = owner_q;
                        end
                    end
                    // A lone requester never hits the second term, so it keeps the bus.
                    if (!owner_req || (accept && hold_inc == HoldMax && others_req)) begin
                        state_d = ARB_IDLE;
                        rr_d    = rr_next;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_q       <= '0;
            hold_q     <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            hold_q     <= hold_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign active           = (state_q == ARB_BUSY) && !reset_in;
    assign bus.d_req_out    = dev_req;
    assign bus.d_addr_out   = active ? owner_addr : '0;
    assign bus.d_we_out     = active && owner_we;
    assign bus.d_wdata_out  = active ? owner_wdata : '0;
    assign bus.h_gnt_out    = accept ? owner_oh : '0;
    // Read return follows the issuing host even after ownership has moved on.
    assign bus.h_rvalid_out = (rd_pend_q && !reset_in) ? rd_oh : '0;
    assign bus.h_rdata_out  = (rd_pend_q && !reset_in) ? bus.d_rdata_in : '0;

    assign dbg_out.state   = state_q;
    assign dbg_out.owner   = HOST_IDX_W'(owner_q);
    assign dbg_out.hold    = hold_q;
    assign dbg_out.rd_pend = rd_pend_q;

`ifdef BUS_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [Hosts];

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < Hosts; i++) begin
            if (reset_in) stat_q[i] <= '0;
            else if (bus.h_gnt_out[i] && stat_q[i] != '1) stat_q[i] <= stat_q[i] + 1'b1;
        end
    end

    for (genvar g = 0; g < Hosts; g++) begin : g_stat
        assign stat_xfer_cnt_out[g*STAT_W +: STAT_W] = stat_q[g];
    end
`else
    assign stat_xfer_cnt_out = '0;
`endif
endmodule

// File: tb/tb_bus_host_arbiter.sv
// Scoreboard bench for bus_host_arbiter: transaction-level reference model, dpram device model.
module tb_bus_host_arbiter;
  import bus_host_arbiter_pkg::*;

  localparam int H  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MH = 4;

  typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } txn_t;
  typedef struct packed { logic [H-1:0] gnt; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } gexp_t;
  typedef struct packed { int due; int host; logic [DW-1:0] data; } rexp_t;

  logic clk = 1'b0;
  logic rst;
  logic [H*STAT_W-1:0] stat;
  arb_dbg_t dbg;
  always #5 clk = ~clk;

  bus_host_arbiter_if #(.Hosts(H), .DataWidth(DW), .AddressWidth(AW)) bus ();

  bus_host_arbiter #(.Hosts(H), .DataWidth(DW), .AddressWidth(AW), .MaxHold(MH)) dut (
    .clk_in(clk), .reset_in(rst), .bus(bus), .stat_xfer_cnt_out(stat), .dbg_out(dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  txn_t host_q[H][$];
  gexp_t gnt_q[$];
  rexp_t exp_q[$];
  logic [H-1:0] gnt_seen = '0;
  logic [DW-1:0] last_rdata[H];
  int rv_cnt[H];
  int cnt_ref[H];
  int total_gnt = 0;
  bit log_en = 1'b0;
  int gnt_log[$];
  logic [DW-1:0] dev_rdata = '0;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 'h40) return 32'hDEADBEEF;
    return 32'hA5000000 ^ (32'(i) * 32'h00010203);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sync_neg();
    @(negedge clk); #3;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // dpram-like device: accepts whenever d_gnt_in is high, read data one cycle later
  initial begin
    logic [DW-1:0] dev_mem [256];
    for (int i = 0; i < 256; i++) dev_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.d_req_out && bus.d_gnt_in) begin
        if (bus.d_we_out) dev_mem[bus.d_addr_out[9:2]] <= bus.d_wdata_out;
        else dev_rdata <= dev_mem[bus.d_addr_out[9:2]];
      end
    end
  end
  assign bus.d_rdata_in = dev_rdata;

  // host driver: each host presents the head of its queue until it sees its grant
  initial begin
    logic [H-1:0] req_v, we_v;
    logic [H*AW-1:0] addr_v;
    logic [H*DW-1:0] wdata_v;
    bus.h_req_in = '0; bus.h_we_in = '0; bus.h_addr_in = '0; bus.h_wdata_in = '0;
    forever begin
      tick();
      for (int h = 0; h < H; h++)
        if (gnt_seen[h] && host_q[h].size() > 0) void'(host_q[h].pop_front());
      gnt_seen = '0;
      req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0;
      for (int h = 0; h < H; h++) begin
        if (host_q[h].size() > 0) begin
          req_v[h] = 1'b1;
          we_v[h] = host_q[h][0].we;
          addr_v[h*AW +: AW] = host_q[h][0].addr;
          wdata_v[h*DW +: DW] = host_q[h][0].wdata;
        end
      end
      bus.h_req_in = req_v; bus.h_we_in = we_v; bus.h_addr_in = addr_v; bus.h_wdata_in = wdata_v;
    end
  end

  // reference model: owner = -1 means nobody holds the bus
  initial begin
    int m_owner, m_rr, m_cnt, o, idx;
    bit acc, others;
    logic [DW-1:0] ref_mem [256];
    logic [H-1:0] one;
    gexp_t ge;
    rexp_t re;
    one = 1;
    m_owner = -1; m_rr = 0; m_cnt = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int h = 0; h < H; h++) cnt_ref[h] = 0;
    forever begin
      @(negedge clk);
      ge = '0;
      if (rst) begin
        m_owner = -1; m_rr = 0; m_cnt = 0;
        exp_q.delete();
        for (int h = 0; h < H; h++) cnt_ref[h] = 0;
      end else if (m_owner < 0) begin
        for (int i = 0; i < H; i++) begin
          if (m_owner < 0 && bus.h_req_in[(m_rr + i) % H]) begin
            m_owner = (m_rr + i) % H;
            m_cnt = 0;
          end
        end
      end else begin
        o = m_owner;
        acc = bus.h_req_in[o] && bus.d_gnt_in;
        if (acc) begin
          ge.gnt = one << o;
          ge.we = bus.h_we_in[o];
          ge.addr = bus.h_addr_in[o*AW +: AW];
          ge.wdata = bus.h_wdata_in[o*DW +: DW];
          idx = int'(ge.addr[9:2]);
          m_cnt = (m_cnt + 1 > MH) ? MH : m_cnt + 1;
          cnt_ref[o]++;
          if (ge.we) ref_mem[idx] = ge.wdata;
          else begin
            re.due = cyc + 1; re.host = o; re.data = ref_mem[idx];
            exp_q.push_back(re);
          end
        end
        others = 1'b0;
        for (int h = 0; h < H; h++) if (h != o && bus.h_req_in[h]) others = 1'b1;
        if (!bus.h_req_in[o] || (acc && m_cnt == MH && others)) begin
          m_owner = -1;
          m_rr = (o + 1) % H;
        end
      end
      gnt_q.push_back(ge);
    end
  end

  // monitor: pops model expectations and compares with what the DUT presents
  initial begin
    gexp_t ge;
    rexp_t re;
    logic [H-1:0] one;
    one = 1;
    for (int h = 0; h < H; h++) begin last_rdata[h] = '0; rv_cnt[h] = 0; end
    forever begin
      @(negedge clk); #2;
      if (gnt_q.size() > 0) begin
        ge = gnt_q.pop_front();
        check("h_gnt", 64'(bus.h_gnt_out), 64'(ge.gnt));
        if (ge.gnt != '0) begin
          check("d_addr", 64'(bus.d_addr_out), 64'(ge.addr));
          check("d_we", 64'(bus.d_we_out), 64'(ge.we));
          if (ge.we) check("d_wdata", 64'(bus.d_wdata_out), 64'(ge.wdata));
        end
      end
      gnt_seen = bus.h_gnt_out;
      for (int h = 0; h < H; h++) begin
        if (bus.h_gnt_out[h]) begin
          total_gnt++;
          if (log_en) gnt_log.push_back(h);
        end
      end
      if (bus.h_rvalid_out != '0) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          re = exp_q.pop_front();
          check("rvalid_host", 64'(bus.h_rvalid_out), 64'(one << re.host));
          check("rdata", 64'(bus.h_rdata_out), 64'(re.data));
          last_rdata[re.host] = bus.h_rdata_out;
          rv_cnt[re.host]++;
        end else begin
          check("unexpected_rvalid", 64'(bus.h_rvalid_out), 64'(0));
        end
      end else begin
        check("rdata_idle_zero", 64'(bus.h_rdata_out), 64'(0));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          re = exp_q.pop_front();
          check("missing_rvalid", 64'(bus.h_rvalid_out), 64'(one << re.host));
        end
      end
    end
  end

  task automatic push_txn(input int h, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    host_q[h].push_back(t);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      sync_neg();
      busy = (exp_q.size() > 0);
      for (int h = 0; h < H; h++) if (host_q[h].size() > 0) busy = 1'b1;
      n++;
    end
    if (busy) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: traffic not drained after %0d cycles", budget);
    end
    repeat (2) sync_neg();
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    int g0, rv0, n;
    int exp_order[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    rst = 1'b1;
    bus.d_gnt_in = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    sync_neg();
    check("rst_state", 64'(dbg.state), 64'(ARB_IDLE));
    check("rst_owner", 64'(dbg.owner), 64'(0));
    check("rst_gnt", 64'(bus.h_gnt_out), 64'(0));
    check("rst_rvalid", 64'(bus.h_rvalid_out), 64'(0));
    check("rst_dreq", 64'(bus.d_req_out), 64'(0));
    check("rst_stat", 64'(stat), 64'(0));

    // host 0 reads 0x100 which holds 0xDEADBEEF
    push_txn(0, 1'b0, 32'h100, '0);
    wait_idle(50);
    check("read_deadbeef", 64'(last_rdata[0]), 64'h0000_0000_DEAD_BEEF);

    // both hosts streaming from a fresh round-robin pointer
    do_reset();
    sync_neg();
    log_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push_txn(0, 1'b0, AW'(i * 4), '0);
      push_txn(1, 1'b0, AW'(i * 4 + 64), '0);
    end
    wait_idle(200);
    log_en = 1'b0;
    if (gnt_log.size() < 12) check("order_len", 64'(gnt_log.size()), 64'(12));
    else for (int i = 0; i < 12; i++) check("grant_order", 64'(gnt_log[i]), 64'(exp_order[i]));

    // host 1 writes, host 0 reads it back
    rv0 = rv_cnt[1];
    push_txn(1, 1'b1, 32'h40, 32'h12345678);
    wait_idle(50);
    push_txn(0, 1'b0, 32'h40, '0);
    wait_idle(50);
    check("write_readback", 64'(last_rdata[0]), 64'h0000_0000_1234_5678);
    check("no_rvalid_h1", 64'(rv_cnt[1]), 64'(rv0));

    // device stalls for several cycles of host 0 ownership
    g0 = total_gnt;
    push_txn(0, 1'b0, 32'h8, '0);
    push_txn(0, 1'b1, 32'hC, 32'hCAFE0001);
    tick(); bus.d_gnt_in = 1'b0;
    repeat (3) tick();
    sync_neg();
    check("stall_no_gnt", 64'(total_gnt - g0), 64'(0));
    tick(); bus.d_gnt_in = 1'b1;
    wait_idle(50);
    check("stall_gnt_total", 64'(total_gnt - g0), 64'(2));

    // reset right after a read is accepted drops the return
    rv0 = rv_cnt[0];
    sync_neg();
    push_txn(0, 1'b0, 32'h100, '0);
    n = 0;
    while (!gnt_seen[0] && n < 20) begin sync_neg(); n++; end
    check("rst_read_accepted", 64'(gnt_seen[0]), 64'(1));
    tick(); rst = 1'b1;
    sync_neg();
    check("rvalid_in_reset", 64'(bus.h_rvalid_out), 64'(0));
    tick(); tick(); rst = 1'b0;
    sync_neg();
    check("post_rst_state", 64'(dbg.state), 64'(ARB_IDLE));
    check("post_rst_owner", 64'(dbg.owner), 64'(0));
    check("post_rst_rvalid", 64'(bus.h_rvalid_out), 64'(0));
    check("post_rst_rdata", 64'(bus.h_rdata_out), 64'(0));
    check("post_rst_daddr", 64'(bus.d_addr_out), 64'(0));
    check("post_rst_stat", 64'(stat), 64'(0));
    check("dropped_read", 64'(rv_cnt[0]), 64'(rv0));

    for (int i = 0; i < 5; i++) push_txn(1, 1'b1, AW'(32'h200 + i * 4), DW'($urandom));
    wait_idle(50);
`ifdef BUS_ARB_STATS_EN
    check("stat_h1_five", 64'(stat[STAT_W +: STAT_W]), 64'(5));
    check("stat_h0_zero", 64'(stat[0 +: STAT_W]), 64'(0));
`else
    check("stat_tied_zero", 64'(stat), 64'(0));
`endif

    // randomized traffic with a flaky device grant
    for (int c = 0; c < 1500; c++) begin
      sync_neg();
      for (int h = 0; h < H; h++)
        if (host_q[h].size() < 3 && $urandom_range(0, 3) == 0)
          push_txn(h, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255) * 4), DW'($urandom));
      tick();
      bus.d_gnt_in = ($urandom_range(0, 4) != 0);
    end
    tick(); bus.d_gnt_in = 1'b1;
    wait_idle(500);
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    for (int h = 0; h < H; h++) begin
`ifdef BUS_ARB_STATS_EN
      check("stat_final", 64'(stat[h*STAT_W +: STAT_W]), 64'((cnt_ref[h] > 65535) ? 65535 : cnt_ref[h]));
`else
      check("stat_final", 64'(stat[h*STAT_W +: STAT_W]), 64'(0));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
Round-robin arbiter that shares one bus device port (the dpram data port behind the bus) between multiple hosts, e.g. core data port plus a future DMA/debug host. Registers ownership, forwards the owner's request to the device, bounds ownership with a hold limit, and routes one-cycle-latency read data back to the issuing host with a valid strobe. Sits between the host side of the bus and the device decode.

Parameters:
Hosts, 2, number of requesting hosts (2..8)
DataWidth, 32, data bus width
AddressWidth, 32, address bus width
MaxHold, 4, max accepted transfers per ownership while another host is requesting (1..255)

Ports:
clk_in  input  1  system clock
reset_in  input  1  synchronous, active-high reset
h_req_in  input  Hosts  per-host request
h_addr_in  input  Hosts*AddressWidth  per-host address, host i at slice i
h_we_in  input  Hosts  per-host write enable
h_wdata_in  input  Hosts*DataWidth  per-host write data
h_gnt_out  output  Hosts  per-host transfer accepted this cycle
h_rvalid_out  output  Hosts  per-host read data valid
h_rdata_out  output  DataWidth  read data, shared by all hosts
d_req_out  output  1  device request
d_addr_out  output  AddressWidth  device address
d_we_out  output  1  device write enable
d_wdata_out  output  DataWidth  device write data
d_gnt_in  input  1  device accepts request (dpram ties high)
d_rdata_in  input  DataWidth  device read data, valid 1 cycle after accepted read
stat_xfer_cnt_out  output  Hosts*16  per-host accepted-transfer count (optional feature)

Behaviour:
- Reset (reset_in high at a clk_in edge): state IDLE, owner 0, rr pointer 0, hold count 0, read pending cleared. All outputs 0. A pending read is dropped; no rvalid after reset.
- States: IDLE, BUSY.
- IDLE: if any h_req_in, pick the first requester searching from rr pointer upward (wrap at Hosts-1). Register it as owner, clear hold count, go to BUSY. No device request issued in IDLE. The pick-to-first-transfer latency is 1 cycle.
- BUSY: d_req_out = h_req_in[owner]. Address, we and wdata are muxed from the owner slice, combinationally.
- Accept = d_req_out && d_gnt_in. When accepted: h_gnt_out[owner] = 1 in the same cycle and the hold count increments (saturating at MaxHold).
- Release BUSY->IDLE when either:
  - h_req_in[owner] = 0, or
  - hold count reaches MaxHold after this accept and any other host is requesting.
- On release, rr pointer = owner+1 mod Hosts. A lone requester keeps ownership indefinitely (no forced release).
- Read: an accepted read (we=0) sets rd_pend with rd_owner. Next cycle h_rvalid_out[rd_owner] = 1 and h_rdata_out = d_rdata_in. This is delivered even if the arbiter is in IDLE or ownership has changed.
- h_rdata_out is 0 when no rvalid. Back-to-back reads yield back-to-back rvalid.
- d_gnt_in low: no accept, no count change, request held stable by the host.
- Simultaneous requests from all hosts in IDLE: rr pointer decides. No host starves beyond (Hosts-1)*(MaxHold+1) cycles of busy bus.

Optional Feature:
BUS_ARB_STATS_EN
- Defined: per-host 16-bit counters increment on each accept for that host, saturate at 16'hFFFF, cleared by reset. Driven on stat_xfer_cnt_out, host i at slice i.
- Undefined: counters not built; stat_xfer_cnt_out tied to 0.

Decomposition:
- bus_pkg: arbiter state typedef (IDLE, BUSY), HOLD_CNT_W and STAT_W=16 constants, host index width helper.
- Sub-module bus_rr_picker: combinational round-robin first-one picker (req vector, pointer -> one-hot + index), reusable for the bus device side.

Test Plan:
- Single host 0 read at 0x100, dpram holds 0xDEADBEEF: h_gnt_out=01 on the cycle after req. h_rvalid_out=01 and h_rdata_out=0xDEADBEEF one cycle later.
- Host 0 and host 1 request continuously from IDLE, MaxHold=4, d_gnt_in=1: grant order is host0 x4, 1 IDLE cycle, host1 x4, 1 IDLE cycle, host0 x4.
- Host 1 write 0x12345678 to 0x40, then host 0 reads 0x40: host 0 gets rvalid with 0x12345678; no rvalid to host 1.
- d_gnt_in held low for 3 cycles during host 0 ownership: no h_gnt_out and hold count unchanged. First accept occurs when d_gnt_in rises.
- Read accepted on the same cycle host 0 drops req: arbiter in IDLE next cycle, yet h_rvalid_out[0]=1 with correct data.
- reset_in asserted the cycle after a read accept: no rvalid, all outputs 0, owner 0. With BUS_ARB_STATS_EN, counts 0 after reset and 5 after five host-1 accepts.
